// File: rtl/sr_mem_arbiter.sv
// Arbitrates a single-port synchronous memory between instruction fetch (port 0)
// and a debug/loader port (port 1) that may lock the memory for a bounded time.
module sr_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_tmo
);
  // state | meaning
  // RR    | round-robin between ports, last_gnt breaks ties
  // LOCK  | port 1 owns the memory until it drops m1_lock or LOCK_MAX expires
  typedef enum logic {ST_RR = 1'b0, ST_LOCK = 1'b1} state_e;

  localparam int CW = $clog2(LOCK_MAX + 1);

  state_e        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;  // 1: port 1 was granted most recently
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_block_q, lock_block_d;
  logic          lock_tmo_q, lock_tmo_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (state_q == ST_LOCK) begin
      m1_gnt = m1_req;
    end else if (m0_req && m1_req) begin
      m0_gnt = last_gnt_q;
      m1_gnt = !last_gnt_q;
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  assign mem_en    = m0_gnt | m1_gnt;
  assign mem_we    = m1_gnt ? m1_we : (m0_gnt & m0_we);
  assign mem_addr  = m1_gnt ? m1_addr : m0_addr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign rdata     = mem_rdata;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign lock_tmo  = lock_tmo_q;

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    lock_cnt_d   = lock_cnt_q;
    lock_block_d = lock_block_q;
    lock_tmo_d   = lock_tmo_q;
    m0_rvalid_d  = m0_gnt & ~m0_we;
    m1_rvalid_d  = m1_gnt & ~m1_we;
    if (m0_gnt) last_gnt_d = 1'b0;
    else if (m1_gnt) last_gnt_d = 1'b1;
    case (state_q)
      ST_RR: begin
        if (m1_gnt && m1_lock && !lock_block_q) begin
          state_d    = ST_LOCK;
          lock_cnt_d = '0;
        end
        if (m0_gnt || !m0_req) lock_block_d = 1'b0;
      end
      ST_LOCK: begin
        if (lock_cnt_q != CW'(LOCK_MAX)) lock_cnt_d = lock_cnt_q + CW'(1);
        // A voluntary release in the expiry cycle is not a forced break.
        if (!m1_lock) begin
          state_d = ST_RR;
        end else if (lock_cnt_q == CW'(LOCK_MAX - 1)) begin
          state_d      = ST_RR;
          lock_tmo_d   = 1'b1;
          lock_block_d = 1'b1;
        end
      end
      default: state_d = ST_RR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RR;
      last_gnt_q   <= 1'b1;
      lock_cnt_q   <= '0;
      lock_block_q <= 1'b0;
      lock_tmo_q   <= 1'b0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_block_q <= lock_block_d;
      lock_tmo_q   <= lock_tmo_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
    end
  end

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Directed and randomized bench for sr_mem_arbiter against a behavioural model
// of the arbitration rules, with a synchronous memory attached to the DUT.
module tb_sr_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LOCK_MAX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata, rdata, mem_rdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_en, mem_we, lock_tmo;

  int checks = 0;
  int errors = 0;

  sr_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lock_tmo(lock_tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'h33};
  endfunction

  // Memory attached to the DUT; unwritten words read back as seed(addr).
  logic [DW-1:0] mem [256];
  bit            written [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : seed(mem_addr);
      end
    end
  end

  // Reference model state
  logic [DW-1:0] mm [256];
  bit            m_locked, m_block, m_tmo, m_rv0, m_rv1;
  int            m_last;       // port that won most recently
  int            m_cnt;        // cycles spent in the current lock
  logic [DW-1:0] m_rdata;
  bit            g0_prev, g1_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_block = 0; m_tmo = 0; m_rv0 = 0; m_rv1 = 0;
    m_last = 1; m_cnt = 0;
  endtask

  task automatic set_in(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit r1, input bit w1, input bit l1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  // Checks one cycle against the model, then advances the model across the edge.
  task automatic step();
    bit e0, e1, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    if (rst) model_reset();
    if (m_locked) begin
      e0 = 0; e1 = m1_req;
    end else if (m0_req && m1_req) begin
      e0 = (m_last == 1); e1 = (m_last == 0);
    end else begin
      e0 = m0_req; e1 = m1_req;
    end
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("mem_en", mem_en, e0 | e1);
    we = e1 ? m1_we : m0_we;
    a  = e1 ? m1_addr : m0_addr;
    d  = e1 ? m1_wdata : m0_wdata;
    if (e0 || e1) begin
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, a);
      if (we) chk("mem_wdata", mem_wdata, d);
    end else begin
      chk("mem_we_idle", mem_we, 0);
    end
    chk("m0_rvalid", m0_rvalid, m_rv0);
    chk("m1_rvalid", m1_rvalid, m1_rvalid === 1'bx ? 1'b0 : m_rv1);
    if (m_rv0 || m_rv1) chk("rdata", rdata, m_rdata);
    chk("lock_tmo", lock_tmo, m_tmo);

    if ((e0 || e1) && !we) m_rdata = mm[a];
    if ((e0 || e1) && we) mm[a] = d;
    if (rst) begin
      m_rv0 = 0; m_rv1 = 0;
    end else begin
      m_rv0 = e0 && !m0_we;
      m_rv1 = e1 && !m1_we;
      if (m_locked) begin
        m_cnt++;
        if (!m1_lock) m_locked = 0;
        else if (m_cnt == LOCK_MAX) begin
          m_locked = 0; m_tmo = 1; m_block = 1;
        end
      end else begin
        if (e1 && m1_lock && !m_block) begin
          m_locked = 1; m_cnt = 0;
        end
        if (e0 || !m0_req) m_block = 0;
      end
      if (e0) m_last = 0;
      if (e1) m_last = 1;
    end
    g0_prev = e0; g1_prev = e1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = seed(i[AW-1:0]);
    model_reset();
    g0_prev = 0; g1_prev = 0;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_tmo", lock_tmo, 0);
    step();
    // Grants follow requests while reset is still asserted.
    set_in(1, 0, 8'h10, 0, 1, 0, 0, 8'h20, 0);
    #1;
    chk("rst_gnt_m0", m0_gnt, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;

    // Continuous contention alternates m0, m1, m0, ...
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 8'h10, 0, 1, 0, 0, 8'h20, 0);
      #1;
      chk("alt_m0", m0_gnt, (i % 2) == 0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Write by m1 then read by m0 in the next cycle.
    set_in(0, 0, 0, 0, 1, 1, 0, 8'h05, 32'hDEADBEEF);
    step();
    set_in(1, 0, 8'h05, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("raw_rvalid", m0_rvalid, 1);
    chk("raw_rdata", rdata, 32'hDEADBEEF);
    step();

    // Lock held across 5 m0 request cycles, then released.
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 1, 8'h30, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, 8'h31, 0, 0, 0, i < 5, 0, 0);
      #1;
      chk("lock_m0_held", m0_gnt, 0);
      step();
    end
    set_in(1, 0, 8'h31, 0, 0, 0, 0, 0, 0);
    #1;
    chk("unlock_m0_gnt", m0_gnt, 1);
    step();

    // Lock held for 20 cycles: forced back to RR after LOCK_MAX cycles.
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      set_in(i != 0, 0, 8'h41, 0, 1, 0, 1, 8'h40, 0);
      #1;
      if (i >= 1 && i <= LOCK_MAX) chk("tmo_m0_held", m0_gnt, 0);
      if (i == LOCK_MAX + 1) begin
        chk("tmo_m0_gnt", m0_gnt, 1);
        chk("tmo_flag", lock_tmo, 1);
      end
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("tmo_sticky", lock_tmo, 1);
    step();

    // Reset pulsed right after an m0 read grant.
    set_in(1, 0, 8'h33, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_drop_rvalid", m0_rvalid, 0);
    step();
    rst = 1'b0;
    set_in(1, 0, 8'h34, 0, 1, 0, 0, 8'h35, 0);
    #1;
    chk("rst_no_rvalid", m0_rvalid, 0);
    chk("rst_tmo_clear", lock_tmo, 0);
    chk("rst_m0_wins", m0_gnt, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Randomized traffic; requesters hold their command until granted.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (g0_prev || !m0_req) begin
        m0_req = ($urandom % 4) != 0;
        m0_we = ($urandom % 3) == 0;
        m0_addr = AW'($urandom % 16);
        m0_wdata = $urandom;
      end
      if (g1_prev || !m1_req) begin
        m1_req = ($urandom % 3) != 0;
        m1_we = ($urandom % 3) == 0;
        m1_addr = AW'($urandom % 16);
        m1_wdata = $urandom;
      end
      if (($urandom % 20) == 0) m1_lock = ~m1_lock;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_mem_arbiter.md
SR_MEM_ARBITER -- requirements
Module: sr_mem_arbiter

Interface
REQ-001 Parameter AW, default 8: word address width of the shared memory.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter LOCK_MAX, default 16: maximum consecutive cycles port 1 may hold a lock.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 m0_req, m0_we  in  1 each  port 0 (instruction fetch) request and write-enable.
REQ-007 m0_addr  in  AW; m0_wdata  in  DW  port 0 address and write data.
REQ-008 m0_gnt  out  1; m0_rvalid  out  1  port 0 grant and read-data-valid.
REQ-009 m1_req, m1_we, m1_lock  in  1 each  port 1 (debug/loader) request, write-enable and lock request.
REQ-010 m1_addr  in  AW; m1_wdata  in  DW  port 1 address and write data.
REQ-011 m1_gnt  out  1; m1_rvalid  out  1  port 1 grant and read-data-valid.
REQ-012 rdata  out  DW  read data, common to both ports, qualified by mN_rvalid.
REQ-013 mem_en, mem_we  out  1 each; mem_addr  out  AW; mem_wdata  out  DW  single-port synchronous memory command.
REQ-014 mem_rdata  in  DW  memory read data, valid one cycle after a read command.
REQ-015 lock_tmo  out  1  sticky flag: a port 1 lock was forcibly broken.

Function
REQ-016 Grants are combinational from current-cycle requests and registered state; at most one of m0_gnt/m1_gnt is 1 per cycle.
REQ-017 Requester holds req, we, addr, wdata stable until the cycle its gnt is 1; the access completes in that cycle.
REQ-018 mem_en = m0_gnt | m1_gnt; mem_we, mem_addr, mem_wdata are taken from the granted port; with no grant mem_we = 0 and mem_addr/mem_wdata are don't-care.
REQ-019 A granted read (we = 0) in cycle N gives mN_rvalid = 1 for exactly one cycle in N+1 with rdata = mem_rdata; granted writes never produce rvalid.
REQ-020 Back-to-back grants every cycle are supported; a read grant in N and any grant in N+1 both complete with no bubble.
REQ-021 State machine states: RR (normal) and LOCK (port 1 owns the memory).
REQ-022 RR, single requester: that port is granted.
REQ-023 RR, both requesting: port not granted most recently (last_gnt register) wins; last_gnt updates on every grant.
REQ-024 RR -> LOCK when m1 is granted with m1_lock = 1, unless lock_block = 1.
REQ-025 LOCK: m1_gnt = m1_req, m0_gnt = 0 regardless of m0_req.
REQ-026 LOCK -> RR on the edge where m1_lock = 0 is sampled; the access granted in that cycle (if any) still completes.
REQ-027 LOCK cycle counter increments each cycle in LOCK; when it reaches LOCK_MAX the next state is RR, lock_tmo sets to 1 and lock_block sets to 1.
REQ-028 lock_block clears when port 0 receives a grant or when m0_req = 0 in RR; while set, m1_lock is ignored.
REQ-029 Lock counter clears on entry to LOCK; width is clog2(LOCK_MAX+1) bits, no wrap.
REQ-030 Both ports requesting in the timeout cycle: transition to RR takes effect next cycle, where port 0 wins (last_gnt = 1).

Reset
REQ-031 While rst = 1: state = RR, last_gnt = 1 (port 0 wins first contention), lock counter = 0, lock_block = 0, lock_tmo = 0, m0_rvalid = m1_rvalid = 0.
REQ-032 Grants are combinational and follow REQ-016..025 from reset state even while rst = 1; rvalid outputs are held 0.
REQ-033 Reset asserted with a read in flight discards it: no rvalid after release.
REQ-034 lock_tmo clears only on reset.

Verification
REQ-035 Both ports request reads continuously from reset, addr 0x10 / 0x20 -> grants alternate m0, m1, m0, ...; each rvalid one cycle after its grant with matching memory word.
REQ-036 m1 writes 0xDEADBEEF to 0x05 then m0 reads 0x05 next cycle -> m0_rvalid with rdata = 0xDEADBEEF two cycles after the write grant.
REQ-037 m1 locks, m0_req held high for 5 cycles, then m1_lock = 0 -> m0_gnt = 0 during lock, m0 granted the cycle after release.
REQ-038 m1_lock held high for 20 cycles with m0 requesting -> forced RR after 16 lock cycles, lock_tmo = 1, m0 granted, m1_lock ignored until m0 granted.
REQ-039 rst pulsed one cycle after a m0 read grant -> no m0_rvalid, lock_tmo = 0, next contention won by m0.
